// File: rtl/rounding_48bit.sv
`default_nettype none
// ============================================================================
//  Module   : rounding_48bit
//  Purpose  : Round-to-nearest-even stage of the single-precision multiplier.
//             Normalizes the 48-bit significand product by at most one bit
//             and rounds it to a 23-bit stored fraction (hidden bit removed).
//             Registered, one cycle of latency.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   rising-edge clock
//    rst_n           in   1   asynchronous active-low reset
//    in_valid        in   1   input_number is valid this cycle
//    input_number    in  48   unsigned product, binary point between 46 and 45
//    out_valid       out  1   registered copy of in_valid
//    rounded_number  out 23   rounded fraction, hidden bit removed
//    norm_shift      out  1   product was >= 2.0; exponent stage adds 1
//    round_carry     out  1   rounding overflowed the fraction; fraction is 0
//    inexact         out  1   guard or sticky was nonzero
// ============================================================================
module rounding_48bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [47:0] input_number,
  output logic        out_valid,
  output logic [22:0] rounded_number,
  output logic        norm_shift,
  output logic        round_carry,
  output logic        inexact
);

  logic        w_hi;
  logic [22:0] w_frac;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [23:0] w_sum;

  // Bit 47 set means the product is in [2.0, 4.0): take the window one bit
  // higher. Otherwise the lower window is used as-is, even for products
  // below 1.0; denormal-style shifting is not this stage's job.
  always_comb begin
    w_hi     = input_number[47];
    w_frac   = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (w_hi) begin
      w_frac   = input_number[46:24];
      w_guard  = input_number[23];
      w_sticky = |input_number[22:0];
    end else begin
      w_frac   = input_number[45:23];
      w_guard  = input_number[22];
      w_sticky = |input_number[21:0];
    end
    // Ties (guard set, sticky clear) round toward an even LSB.
    w_round_up = w_guard & (w_sticky | w_frac[0]);
    // The extra MSB catches the all-ones fraction rolling over; the low
    // 23 bits are then zero, which is exactly the wanted fraction.
    w_sum      = {1'b0, w_frac} + {23'd0, w_round_up};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      rounded_number <= '0;
      norm_shift     <= 1'b0;
      round_carry    <= 1'b0;
      inexact        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Data outputs hold their last result while no new input arrives.
      if (in_valid) begin
        rounded_number <= w_sum[22:0];
        norm_shift     <= w_hi;
        round_carry    <= w_sum[23];
        inexact        <= w_guard | w_sticky;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rounding_48bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rounding_48bit
//  Purpose  : Directed self-checking bench for rounding_48bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rounding_48bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [47:0] input_number;
  logic        out_valid;
  logic [22:0] rounded_number;
  logic        norm_shift;
  logic        round_carry;
  logic        inexact;

  int checks = 0;
  int passes = 0;

  rounding_48bit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .input_number   (input_number),
    .out_valid      (out_valid),
    .rounded_number (rounded_number),
    .norm_shift     (norm_shift),
    .round_carry    (round_carry),
    .inexact        (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      passes++;
  endtask

  // Check all four result fields plus out_valid against expected values.
  task automatic check_result(input string tag, input logic [22:0] rn, input logic ns,
                              input logic rc, input logic inx);
    check({tag, "/valid"}, {47'd0, out_valid},      48'd1);
    check({tag, "/rn"},    {25'd0, rounded_number}, {25'd0, rn});
    check({tag, "/ns"},    {47'd0, norm_shift},     {47'd0, ns});
    check({tag, "/rc"},    {47'd0, round_carry},    {47'd0, rc});
    check({tag, "/inx"},   {47'd0, inexact},        {47'd0, inx});
  endtask

  // Present one valid input, then inspect the result just after the edge.
  task automatic apply(input string tag, input logic [47:0] v, input logic [22:0] rn,
                       input logic ns, input logic rc, input logic inx);
    @(negedge clk);
    in_valid     = 1'b1;
    input_number = v;
    @(posedge clk);
    #1;
    check_result(tag, rn, ns, rc, inx);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/valid"}, {47'd0, out_valid},      48'd0);
    check({tag, "/rn"},    {25'd0, rounded_number}, 48'd0);
    check({tag, "/ns"},    {47'd0, norm_shift},     48'd0);
    check({tag, "/rc"},    {47'd0, round_carry},    48'd0);
    check({tag, "/inx"},   {47'd0, inexact},        48'd0);
  endtask

  logic [47:0] b2b_in [3];
  logic [22:0] b2b_rn [3];

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    input_number = '0;
    #1;
    check_all_zero("reset");

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // frac=0x2AAAAA, guard=1, sticky=1 -> round up
    apply("alt_a",   48'hAAAAAAAAAAAA, 23'h2AAAAB, 1'b1, 1'b0, 1'b1);
    // 0x802AABFEAAAA: frac=0x002AAB, guard=1, sticky=1 -> round up
    apply("pattern", 48'b100000000010101010101011111111101010101010101010,
          23'h002AAC, 1'b1, 1'b0, 1'b1);
    // Tie with even LSB stays put
    apply("tie_even", 48'h800000800000, 23'h000000, 1'b1, 1'b0, 1'b1);
    // Tie with odd LSB rounds to even
    apply("tie_odd",  48'h800001800000, 23'h000002, 1'b1, 1'b0, 1'b1);
    // Unshifted path tie, odd LSB
    apply("tie_lo",   48'h400000C00000, 23'h000002, 1'b0, 1'b0, 1'b1);
    // All-ones fraction rolls over to 2.0/4.0
    apply("ovf",      48'hFFFFFF800000, 23'h000000, 1'b1, 1'b1, 1'b1);
    // Exact 1.0
    apply("exact",    48'h400000000000, 23'h000000, 1'b0, 1'b0, 1'b0);
    // Below 1.0, no extra shift: frac=0, guard=1, sticky=1 -> 1
    apply("sub_one",  48'h000000400001, 23'h000001, 1'b0, 1'b0, 1'b1);
    // Sticky only: inexact but no rounding
    apply("sticky",   48'h800000000001, 23'h000000, 1'b1, 1'b0, 1'b1);

    // Three back-to-back valids, then a gap
    b2b_in[0] = 48'h800003800000; b2b_rn[0] = 23'h000004;
    b2b_in[1] = 48'h800005000000; b2b_rn[1] = 23'h000005;
    b2b_in[2] = 48'h800006C00000; b2b_rn[2] = 23'h000007;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      input_number = b2b_in[i];
      @(posedge clk);
      #1;
      check($sformatf("b2b%0d/valid", i), {47'd0, out_valid}, 48'd1);
      check($sformatf("b2b%0d/rn", i), {25'd0, rounded_number}, {25'd0, b2b_rn[i]});
    end
    @(negedge clk);
    in_valid     = 1'b0;
    input_number = 48'hFFFFFFFFFFFF;
    @(posedge clk);
    #1;
    check("gap/valid", {47'd0, out_valid},      48'd0);
    check("gap/rn",    {25'd0, rounded_number}, {25'd0, b2b_rn[2]});
    check("gap/ns",    {47'd0, norm_shift},     48'd1);
    check("gap/rc",    {47'd0, round_carry},    48'd0);
    check("gap/inx",   {47'd0, inexact},        48'd1);

    // Asynchronous reset between edges while a result is showing
    apply("pre_rst", 48'hFFFFFF800000, 23'h000000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    input_number = 48'hAAAAAAAAAAAA;  // in_valid still high: in flight
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");

    // Release with no valid input: nothing from before reset appears
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst/valid", {47'd0, out_valid}, 48'd0);
    apply("post_rst", 48'h800001800000, 23'h000002, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Absolute time bound so the run cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
